// File: rtl/map_pkg.sv
// Shared definitions for the 8-state max-log-MAP decoder: trellis constants,
// metric saturation and the forward-recursion FSM encoding.
package map_pkg;

  localparam int NUM_STATES = 8;
  localparam int AM_W       = 16;

  typedef enum logic [2:0] {IDLE, WINIT, RUN, WRITE, DONE} fsm_t;

  // Predecessor of next state n along the branch whose oldest register bit is s3
  function automatic logic [2:0] pred(input logic [2:0] n, input logic s3);
    return ((n & 3'b011) << 1) | {2'b00, s3};
  endfunction

  function automatic logic ubit(input logic [2:0] n, input logic s3);
    return (^(n & 3'b101)) ^ s3;
  endfunction

  function automatic logic pbit(input logic [2:0] n, input logic s3);
    return (^(n & 3'b110)) ^ s3;
  endfunction

  function automatic logic signed [AM_W-1:0] sat_am(input logic signed [AM_W+1:0] x);
    if (x > $signed({3'b000, {(AM_W-1){1'b1}}}))
      return {1'b0, {(AM_W-1){1'b1}}};
    else if (x < $signed({3'b111, {(AM_W-1){1'b0}}}))
      return {1'b1, {(AM_W-1){1'b0}}};
    else
      return x[AM_W-1:0];
  endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select for one trellis state: the larger of two path metrics
// extended by their branch metrics, at full precision (no normalization).
module acs_unit
  import map_pkg::*;
(
  input  logic signed [AM_W-1:0] metric_a,
  input  logic signed [AM_W-1:0] metric_b,
  input  logic signed [AM_W:0]   gamma_a,
  input  logic signed [AM_W:0]   gamma_b,
  output logic signed [AM_W+1:0] raw
);

  logic signed [AM_W+1:0] sum_a;
  logic signed [AM_W+1:0] sum_b;

  assign sum_a = {{2{metric_a[AM_W-1]}}, metric_a} + {gamma_a[AM_W], gamma_a};
  assign sum_b = {{2{metric_b[AM_W-1]}}, metric_b} + {gamma_b[AM_W], gamma_b};
  assign raw   = (sum_a >= sum_b) ? sum_a : sum_b;

endmodule

// File: rtl/alpha_forward_recursion.sv
// Forward alpha recursion: one LLR pair per trellis step, normalized 8-metric
// vectors written to alpha_SRAM at base address 8*k, one step every 2 cycles.
module alpha_forward_recursion
  import map_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int LLR_W     = 8,
  parameter int INIT_NEG  = -4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [LLR_W-1:0] sys_llr,
  input  logic signed [LLR_W-1:0] par_llr,
  output logic                    sram_wr,
  output logic [7:0]              sram_addr,
  output logic signed [AM_W-1:0]  sram_data0,
  output logic signed [AM_W-1:0]  sram_data1,
  output logic signed [AM_W-1:0]  sram_data2,
  output logic signed [AM_W-1:0]  sram_data3,
  output logic signed [AM_W-1:0]  sram_data4,
  output logic signed [AM_W-1:0]  sram_data5,
  output logic signed [AM_W-1:0]  sram_data6,
  output logic signed [AM_W-1:0]  sram_data7,
  output logic                    busy,
  output logic                    done
);

  localparam int KW = $clog2(FRAME_LEN + 1);
  localparam logic signed [AM_W-1:0] INIT_AM = AM_W'(INIT_NEG);

  fsm_t                   state;
  fsm_t                   state_nxt;
  logic [KW-1:0]          k;
  logic                   accept;
  logic signed [AM_W-1:0] alpha_p1 [NUM_STATES];
  logic signed [AM_W:0]   gam_p0   [4];
  logic signed [AM_W+1:0] raw_p0   [NUM_STATES];
  logic signed [AM_W-1:0] norm_p0  [NUM_STATES];

  // Stage p0: branch metrics indexed by {u,p}, ACS, normalization against state 0
  assign gam_p0[0] = '0;
  assign gam_p0[1] = {{(AM_W+1-LLR_W){par_llr[LLR_W-1]}}, par_llr};
  assign gam_p0[2] = {{(AM_W+1-LLR_W){sys_llr[LLR_W-1]}}, sys_llr};
  assign gam_p0[3] = gam_p0[1] + gam_p0[2];

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam logic [2:0] NI = 3'(n);
    localparam logic [2:0] SA = pred(NI, 1'b0);
    localparam logic [2:0] SB = pred(NI, 1'b1);
    localparam logic [1:0] GA = {ubit(NI, 1'b0), pbit(NI, 1'b0)};
    localparam logic [1:0] GB = {ubit(NI, 1'b1), pbit(NI, 1'b1)};

    acs_unit u_acs (
      .metric_a (alpha_p1[SA]),
      .metric_b (alpha_p1[SB]),
      .gamma_a  (gam_p0[GA]),
      .gamma_b  (gam_p0[GB]),
      .raw      (raw_p0[n])
    );

    assign norm_p0[n] = sat_am(raw_p0[n] - raw_p0[0]);
  end

  assign accept = (state == RUN) && in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WINIT;
      WINIT:   state_nxt = RUN;
      RUN:     if (in_valid) state_nxt = WRITE;
      WRITE:   state_nxt = (k == KW'(FRAME_LEN)) ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: metric registers, step counter and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      for (int i = 0; i < NUM_STATES; i++) alpha_p1[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        k           <= '0;
        alpha_p1[0] <= '0;
        for (int i = 1; i < NUM_STATES; i++) alpha_p1[i] <= INIT_AM;
      end else if (accept) begin
        k <= k + 1'b1;
        for (int i = 0; i < NUM_STATES; i++) alpha_p1[i] <= norm_p0[i];
      end
    end
  end

  assign in_ready   = (state == RUN);
  assign sram_wr    = (state == WINIT) || (state == WRITE);
  assign sram_addr  = 8'({k, 3'b000});
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign sram_data0 = alpha_p1[0];
  assign sram_data1 = alpha_p1[1];
  assign sram_data2 = alpha_p1[2];
  assign sram_data3 = alpha_p1[3];
  assign sram_data4 = alpha_p1[4];
  assign sram_data5 = alpha_p1[5];
  assign sram_data6 = alpha_p1[6];
  assign sram_data7 = alpha_p1[7];

endmodule
